reg_scoreboard: RTL and testbench
=================================

# reg_scoreboard

Issue-side register scoreboard for the pipelined CPU. It tracks every in-flight destination register between instruction issue and register-file writeback. It gates issue on source-operand readiness (RAW) and on a pending write to the same destination (WAW). The writeback stage drives its release port with the same `wb_valid`/`wb_rd` pair that feeds the register-file write port.

## Interface
Parameters:
- `LATW`, default 3: width of the per-register ready countdown; maximum issue latency is 2^LATW-1.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `issue_valid`, in, 1: the decode stage presents an instruction.
- `issue_rs`, in, 5: first source register.
- `issue_use_rs`, in, 1: the instruction reads `issue_rs`.
- `issue_rt`, in, 5: second source register.
- `issue_use_rt`, in, 1: the instruction reads `issue_rt`.
- `issue_rd`, in, 5: destination register.
- `issue_wr`, in, 1: the instruction writes `issue_rd`.
- `issue_lat`, in, LATW: cycles after issue before the result becomes forwardable.
- `issue_ready`, out, 1: no hazard; the instruction is accepted at this edge if `issue_valid` is high.
- `wb_valid`, in, 1: a register-file write occurs this cycle.
- `wb_rd`, in, 5: the register being written back.
- `flush`, in, 1: pipeline flush; discards all pending entries.
- `busy_mask`, out, 32: bit n set means register n has a write in flight.
- `pending_cnt`, out, 6: number of set bits in `busy_mask`.
- `wb_err`, out, 1: sticky flag; set by a writeback to a register that is not busy.

## Operation
- State per register n (1..31): `busy[n]` and `cnt[n]` (LATW bits). Register 0 is never busy and never counted.
- RAW hazard on rs: `issue_use_rs` && rs≠0 && `busy[rs]` && `cnt[rs]`≠0. The rt hazard is identical.
- WAW hazard: `issue_wr` && rd≠0 && `busy[rd]` (in-order writeback is enforced).
- `issue_ready` = no RAW hazard and no WAW hazard.
  - It is purely combinational from the registered state and the issue fields.
  - It is independent of `issue_valid`, `wb_*` and `flush` in the same cycle.
- Accept = `issue_valid` && `issue_ready` && !`flush`.
- On accept with `issue_wr` && rd≠0: `busy[rd]`←1, `cnt[rd]`←`issue_lat`.
- Every cycle, each busy entry with `cnt`>0 that is not loaded this cycle decrements by 1. The count saturates at 0.
- Writeback (`wb_valid` && wb_rd≠0):
  - If `busy[wb_rd]` is set: clear it and set `cnt[wb_rd]`←0.
  - If not set: state is unchanged and `wb_err`←1.
- Same-cycle accept and writeback to the same rd cannot both update state, because WAW stalls that accept.
  - Writeback and accept to different registers both apply.
- `pending_cnt` is a registered counter: +1 per accepted write, −1 per valid writeback of a busy register, net change applied when both occur.
- `flush`:
  - All `busy`, all `cnt` and `pending_cnt` clear at the edge.
  - Any accept or writeback in the same cycle is ignored.
  - `wb_err` is kept.
- Reset: `busy_mask`=0, all `cnt`=0, `pending_cnt`=0, `wb_err`=0, so `issue_ready`=1 for any fields. Reset overrides `flush`, issue and writeback.

## Timing
- Producer accepted in cycle c with latency L: `busy` and `cnt`=L are visible from cycle c+1, and `cnt` = L−k in cycle c+1+k.
- A RAW dependent stalls in cycles c+1..c+L and is accepted at the earliest in cycle c+L+1.
  - L=0 causes no RAW stall; the forwarding network supplies the value.
- A writeback in cycle w clears `busy` from cycle w+1. A WAW-stalled instruction is accepted at the earliest in cycle w+1; there is no same-cycle release.
- `busy_mask` and `pending_cnt` are registered outputs with one-cycle latency after accept, writeback or flush.
- `issue_ready` has zero latency relative to the issue fields.

## Test plan
- After reset: any issue fields give `issue_ready`=1, and `busy_mask`=0, `pending_cnt`=0, `wb_err`=0.
- Issue rd=5, lat=3 in cycle 0, then hold issue rs=5 (`issue_use_rs`=1) -> `issue_ready`=0 in cycles 1–3, =1 in cycle 4; `busy_mask`=0x20.
- Issue rd=8, lat=0, then issue rd=8 again -> second instruction is stalled until `wb_valid` with wb_rd=8 in cycle w; accepted in cycle w+1; `pending_cnt` goes 1→0→1.
- Issue rd=0 with `issue_wr`=1 -> `busy_mask` stays 0, `pending_cnt` stays 0; rs=0 never stalls.
- Issue rd=3 and rd=4, then `flush` together with `issue_valid` (rd=6) and `wb_valid` (wb_rd=3) -> next cycle `busy_mask`=0, `pending_cnt`=0, and register 6 is not busy.
- `wb_valid` with wb_rd=9 while 9 is not busy -> `wb_err`=1 from the next cycle and stays set through a flush; it is cleared only by `reset`.

Source files
------------

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: issue-side register scoreboard.
// Tracks destination registers that have been issued but not yet written back.
// Issue is gated on source readiness (RAW) and on a pending write to the same
// destination (WAW).
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   issue_valid             decode presents an instruction
//   issue_rs/_use_rs        first source register and its use flag
//   issue_rt/_use_rt        second source register and its use flag
//   issue_rd/_wr            destination register and its write flag
//   issue_lat               cycles after issue until the result is forwardable
//   issue_ready             no hazard (combinational from state + issue fields)
//   wb_valid/wb_rd          register-file writeback, releases the entry
//   flush                   discard all pending entries
//   busy_mask               bit n set: register n has a write in flight
//   pending_cnt             number of set bits in busy_mask
//   wb_err                  sticky: writeback to a register that was not busy

// Per-register entry: busy flag plus ready countdown.
// load and retire are never both asserted for one entry: an accept to a busy
// register is blocked by the WAW check, and retire only fires on busy entries.
module sb_entry #(
    parameter int LATW = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            load,
    input  logic [LATW-1:0] lat,
    input  logic            retire,
    output logic            busy,
    output logic [LATW-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (load) begin
            busy <= 1'b1;
            cnt  <= lat;
        end else if (retire) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (busy && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end
endmodule

module reg_scoreboard #(
    parameter int LATW = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rs,
    input  logic            issue_use_rs,
    input  logic [4:0]      issue_rt,
    input  logic            issue_use_rt,
    input  logic [4:0]      issue_rd,
    input  logic            issue_wr,
    input  logic [LATW-1:0] issue_lat,
    output logic            issue_ready,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic            flush,
    output logic [31:0]     busy_mask,
    output logic [5:0]      pending_cnt,
    output logic            wb_err
);
    logic [31:0][LATW-1:0] cnt;
    logic [31:0]           load;
    logic [31:0]           retire;
    logic                  rs_haz, rt_haz, waw_haz;
    logic                  accept, alloc, wb_hit, wb_miss;

    // Register 0 is hardwired: never busy, never counting.
    assign busy_mask[0] = 1'b0;
    assign cnt[0]       = '0;

    // A source is ready once its producer's countdown reaches zero, even while
    // the entry stays busy until writeback (value comes from forwarding).
    assign rs_haz  = issue_use_rs && (issue_rs != 5'd0) && busy_mask[issue_rs] && (cnt[issue_rs] != '0);
    assign rt_haz  = issue_use_rt && (issue_rt != 5'd0) && busy_mask[issue_rt] && (cnt[issue_rt] != '0);
    assign waw_haz = issue_wr && (issue_rd != 5'd0) && busy_mask[issue_rd];

    assign issue_ready = !(rs_haz || rt_haz || waw_haz);

    assign accept  = issue_valid && issue_ready && !flush;
    assign alloc   = accept && issue_wr && (issue_rd != 5'd0);
    assign wb_hit  = !flush && wb_valid && (wb_rd != 5'd0) && busy_mask[wb_rd];
    assign wb_miss = !flush && wb_valid && (wb_rd != 5'd0) && !busy_mask[wb_rd];

    always_comb begin
        load   = '0;
        retire = '0;
        if (alloc)  load[issue_rd] = 1'b1;
        if (wb_hit) retire[wb_rd]  = 1'b1;
    end

    genvar n;
    generate
        for (n = 1; n < 32; n++) begin : g_ent
            sb_entry #(.LATW(LATW)) u_ent (
                .clk    (clk),
                .reset  (reset),
                .clear  (flush),
                .load   (load[n]),
                .lat    (issue_lat),
                .retire (retire[n]),
                .busy   (busy_mask[n]),
                .cnt    (cnt[n])
            );
        end
    endgenerate

    // Population count kept incrementally alongside the busy bits.
    always_ff @(posedge clk) begin
        if (reset || flush)
            pending_cnt <= '0;
        else
            pending_cnt <= pending_cnt + 6'(alloc) - 6'(wb_hit);
    end

    // Sticky; survives flush, only reset clears it.
    always_ff @(posedge clk) begin
        if (reset)
            wb_err <= 1'b0;
        else if (wb_miss)
            wb_err <= 1'b1;
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed testbench for reg_scoreboard. Inputs change on the falling edge,
// outputs are checked 1ns later, and the DUT samples on the rising edge.
module tb_reg_scoreboard;
    localparam int LATW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            issue_valid;
    logic [4:0]      issue_rs;
    logic            issue_use_rs;
    logic [4:0]      issue_rt;
    logic            issue_use_rt;
    logic [4:0]      issue_rd;
    logic            issue_wr;
    logic [LATW-1:0] issue_lat;
    logic            issue_ready;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic            flush;
    logic [31:0]     busy_mask;
    logic [5:0]      pending_cnt;
    logic            wb_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_scoreboard #(.LATW(LATW)) dut (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_rs     (issue_rs),
        .issue_use_rs (issue_use_rs),
        .issue_rt     (issue_rt),
        .issue_use_rt (issue_use_rt),
        .issue_rd     (issue_rd),
        .issue_wr     (issue_wr),
        .issue_lat    (issue_lat),
        .issue_ready  (issue_ready),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .flush        (flush),
        .busy_mask    (busy_mask),
        .pending_cnt  (pending_cnt),
        .wb_err       (wb_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 0; issue_rs = 0; issue_use_rs = 0; issue_rt = 0; issue_use_rt = 0;
        issue_rd = 0; issue_wr = 0; issue_lat = 0; wb_valid = 0; wb_rd = 0; flush = 0;
    endtask

    task automatic issue(input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
                         input logic [4:0] rd, input logic wr, input logic [LATW-1:0] lat);
        issue_valid = 1; issue_rs = rs; issue_use_rs = urs; issue_rt = rt; issue_use_rt = urt;
        issue_rd = rd; issue_wr = wr; issue_lat = lat;
    endtask

    task automatic next();
        @(negedge clk);
        idle();
    endtask

    initial begin
        idle();
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;

        // Reset state: any fields are ready.
        issue(5'd5, 1, 5'd7, 1, 5'd5, 1, 3'd7); #1;
        check("rst_ready", issue_ready, 1);
        check("rst_busy", busy_mask, 0);
        check("rst_pend", pending_cnt, 0);
        check("rst_err", wb_err, 0);
        idle();

        // RAW: rd=5 lat=3 in cycle 0, rs=5 stalls cycles 1..3, ready in cycle 4.
        issue(5'd0, 0, 5'd0, 0, 5'd5, 1, 3'd3); #1;
        check("raw_prod_ready", issue_ready, 1);
        for (int k = 1; k <= 3; k++) begin
            next();
            issue(5'd5, 1, 5'd0, 0, 5'd0, 0, 3'd0); #1;
            check($sformatf("raw_stall_c%0d", k), issue_ready, 0);
        end
        check("raw_busy", busy_mask, 32'h20);
        check("raw_pend", pending_cnt, 1);
        next();
        issue(5'd5, 1, 5'd0, 0, 5'd0, 0, 3'd0); #1;
        check("raw_ready_c4", issue_ready, 1);
        next();
        issue(5'd0, 0, 5'd5, 1, 5'd0, 0, 3'd0); #1;
        check("raw_sat_rt_c5", issue_ready, 1);
        idle(); wb_valid = 1; wb_rd = 5;
        next(); #1;
        check("raw_wb_busy", busy_mask, 0);
        check("raw_wb_pend", pending_cnt, 0);

        // WAW: rd=8 lat=0, lat-0 RAW never stalls, second rd=8 stalls until wb.
        issue(5'd0, 0, 5'd0, 0, 5'd8, 1, 3'd0);
        next();
        issue(5'd8, 1, 5'd8, 1, 5'd0, 0, 3'd0); #1;
        check("lat0_no_raw", issue_ready, 1);
        check("waw_pend1", pending_cnt, 1);
        issue(5'd0, 0, 5'd0, 0, 5'd8, 1, 3'd0); #1;
        check("waw_stall0", issue_ready, 0);
        next();
        issue(5'd0, 0, 5'd0, 0, 5'd8, 1, 3'd0); #1;
        check("waw_stall1", issue_ready, 0);
        wb_valid = 1; wb_rd = 8; #1;
        check("waw_no_same_cycle", issue_ready, 0);
        next();
        issue(5'd0, 0, 5'd0, 0, 5'd8, 1, 3'd0); #1;
        check("waw_release_pend0", pending_cnt, 0);
        check("waw_release_busy", busy_mask, 0);
        check("waw_accept_ready", issue_ready, 1);
        next(); #1;
        check("waw_reissue_pend", pending_cnt, 1);
        check("waw_reissue_busy", busy_mask, 32'h100);
        wb_valid = 1; wb_rd = 8;
        next(); #1;
        check("waw_clean_pend", pending_cnt, 0);

        // Register 0 as destination and as source.
        issue(5'd0, 1, 5'd0, 1, 5'd0, 1, 3'd7); #1;
        check("r0_ready", issue_ready, 1);
        next(); #1;
        check("r0_busy", busy_mask, 0);
        check("r0_pend", pending_cnt, 0);

        // Flush with simultaneous issue and writeback.
        issue(5'd0, 0, 5'd0, 0, 5'd3, 1, 3'd7);
        next();
        issue(5'd0, 0, 5'd0, 0, 5'd4, 1, 3'd7);
        next(); #1;
        check("pre_flush_busy", busy_mask, 32'h18);
        check("pre_flush_pend", pending_cnt, 2);
        issue(5'd0, 0, 5'd0, 0, 5'd6, 1, 3'd2);
        wb_valid = 1; wb_rd = 3; flush = 1;
        next();
        issue(5'd3, 1, 5'd4, 1, 5'd6, 1, 3'd0); #1;
        check("flush_busy", busy_mask, 0);
        check("flush_pend", pending_cnt, 0);
        check("flush_ready", issue_ready, 1);
        check("flush_err", wb_err, 0);
        idle();

        // Accept and writeback to different registers in the same cycle.
        issue(5'd0, 0, 5'd0, 0, 5'd10, 1, 3'd2);
        next();
        issue(5'd0, 0, 5'd0, 0, 5'd11, 1, 3'd1);
        wb_valid = 1; wb_rd = 10;
        next(); #1;
        check("mix_busy", busy_mask, 32'h800);
        check("mix_pend", pending_cnt, 1);

        // Writeback to a non-busy register: sticky error, survives flush.
        wb_valid = 1; wb_rd = 9;
        next(); #1;
        check("err_set", wb_err, 1);
        check("err_busy", busy_mask, 32'h800);
        check("err_pend", pending_cnt, 1);
        flush = 1;
        next(); #1;
        check("err_after_flush", wb_err, 1);
        check("err_flush_busy", busy_mask, 0);
        reset = 1;
        next(); #1;
        reset = 0;
        check("err_reset", wb_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
